risc_multicycle_core: RTL

- Parametrised multicycle successor to the single-cycle 16-bit Risc core.
- Runs a fixed 16-bit instruction set over DATA_W-bit data through a FETCH/DECODE/EXEC/MEM/WB state machine.
- Output register becomes a valid/ready stream. Halt is a clean state with a `done` flag, not clock gating.
- Program is loaded through the external write port while the core is idle or halted.

---
 rtl/risc_multicycle_core.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/risc_multicycle_core.sv
// Multicycle core for the fixed 16-bit instruction set over a DATA_W datapath.
// state  | meaning
// IDLE   | after reset; program writes and start accepted
// FETCH  | IR <= IMEM[PC]
// DECODE | latch A/B, dispatch; OUT loads the stream register here
// EXEC   | ALU, effective address, branch/jump resolution
// MEM    | data memory store, or load into MDR
// WB     | register write-back, PC+1
// OUTW   | hold the OUT beat until out_ready
// HALT   | stopped on HLT, done=1; program writes and start accepted
module risc_multicycle_core #(
  parameter int DATA_W  = 16,
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8,
  parameter int NREG    = 8
) (
  input  logic               clk,
  input  logic               PC_rst,
  input  logic               ext_we,
  input  logic [IMEM_AW-1:0] ext_addr,
  input  logic [15:0]        ext_data,
  input  logic               start,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic [IMEM_AW-1:0] pc
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_OUTW, S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4, OP_LDI = 4'h5, OP_LD = 4'h6, OP_ST = 4'h7;
  localparam logic [3:0] OP_BEQ = 4'h8, OP_BNE = 4'h9, OP_JMP = 4'hA, OP_JAL = 4'hB;
  localparam logic [3:0] OP_OUT = 4'hC, OP_NOPD = 4'hD, OP_NOPE = 4'hE, OP_HLT = 4'hF;

  state_t              r_state, w_state_nxt;
  logic [15:0]         r_imem [2**IMEM_AW];
  logic [DATA_W-1:0]   r_dmem [2**DMEM_AW];
  logic [DATA_W-1:0]   r_regs [NREG];
  logic [IMEM_AW-1:0]  r_pc;
  logic [15:0]         r_ir;
  logic [DATA_W-1:0]   r_a, r_b, r_res, r_mdr, r_out_data;
  logic                r_out_valid, r_flag_z, r_flag_c;

  logic [3:0]          w_op;
  logic [2:0]          w_rd, w_ra, w_rb;
  logic [DATA_W-1:0]   w_imm6, w_imm8;
  logic [DATA_W:0]     w_add, w_addi, w_sub;
  logic [DATA_W-1:0]   w_alu_res;
  logic                w_alu_c, w_flags_we;
  logic [IMEM_AW-1:0]  w_pc_plus1, w_pc_br, w_pc_jmp, w_pc_tgt;
  logic [DMEM_AW-1:0]  w_daddr;
  logic                w_imem_we, w_pc_clr, w_pc_inc, w_pc_load, w_ir_load, w_ab_load, w_exec;
  logic                w_mem_we, w_mdr_load, w_reg_we, w_out_load, w_out_clr;
  logic [2:0]          w_reg_wa;
  logic [DATA_W-1:0]   w_reg_wd;

  assign w_op   = r_ir[15:12];
  assign w_rd   = r_ir[11:9];
  assign w_ra   = r_ir[8:6];
  assign w_rb   = r_ir[5:3];
  assign w_imm6 = DATA_W'($signed(r_ir[5:0]));
  assign w_imm8 = DATA_W'($signed(r_ir[7:0]));

  assign w_add  = {1'b0, r_a} + {1'b0, r_b};
  assign w_addi = {1'b0, r_a} + {1'b0, w_imm6};
  assign w_sub  = {1'b0, r_a} - {1'b0, r_b};

  assign w_pc_plus1 = r_pc + IMEM_AW'(1);
  assign w_pc_br    = w_pc_plus1 + IMEM_AW'($signed(r_ir[7:0]));
  assign w_pc_jmp   = IMEM_AW'(r_ir[11:0]);
  assign w_daddr    = r_res[DMEM_AW-1:0];

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != S_IDLE) && (r_state != S_HALT);
  assign done      = (r_state == S_HALT);
  assign pc        = r_pc;

  // LD/ST reuse the ADDI sum as the effective address.
  always_comb begin
    w_alu_res  = w_addi[DATA_W-1:0];
    w_alu_c    = 1'b0;
    w_flags_we = 1'b1;
    case (w_op)
      OP_ADD:  {w_alu_c, w_alu_res} = w_add;
      OP_SUB:  begin w_alu_res = w_sub[DATA_W-1:0]; w_alu_c = ~w_sub[DATA_W]; end
      OP_AND:  w_alu_res = r_a & r_b;
      OP_OR:   w_alu_res = r_a | r_b;
      OP_ADDI: {w_alu_c, w_alu_res} = w_addi;
      OP_LDI:  begin w_alu_res = w_imm8; w_flags_we = 1'b0; end
      default: w_flags_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge PC_rst) begin
    if (PC_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_imem_we   = 1'b0;
    w_pc_clr    = 1'b0;
    w_pc_inc    = 1'b0;
    w_pc_load   = 1'b0;
    w_pc_tgt    = w_pc_plus1;
    w_ir_load   = 1'b0;
    w_ab_load   = 1'b0;
    w_exec      = 1'b0;
    w_mem_we    = 1'b0;
    w_mdr_load  = 1'b0;
    w_reg_we    = 1'b0;
    w_reg_wa    = w_rd;
    w_reg_wd    = r_res;
    w_out_load  = 1'b0;
    w_out_clr   = 1'b0;
    case (r_state)
      S_IDLE, S_HALT: begin
        w_imem_we = ext_we;
        if (start) begin
          w_pc_clr    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_ir_load   = 1'b1;
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        w_ab_load = 1'b1;
        case (w_op)
          OP_HLT:           w_state_nxt = S_HALT;
          OP_NOPD, OP_NOPE: begin w_pc_inc = 1'b1; w_state_nxt = S_FETCH; end
          OP_OUT:           begin w_out_load = 1'b1; w_state_nxt = S_OUTW; end
          default:          w_state_nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        w_exec = 1'b1;
        case (w_op)
          OP_LD, OP_ST: w_state_nxt = S_MEM;
          OP_BEQ: begin
            w_pc_load   = 1'b1;
            w_pc_tgt    = r_flag_z ? w_pc_br : w_pc_plus1;
            w_state_nxt = S_FETCH;
          end
          OP_BNE: begin
            w_pc_load   = 1'b1;
            w_pc_tgt    = r_flag_z ? w_pc_plus1 : w_pc_br;
            w_state_nxt = S_FETCH;
          end
          OP_JMP: begin
            w_pc_load   = 1'b1;
            w_pc_tgt    = w_pc_jmp;
            w_state_nxt = S_FETCH;
          end
          OP_JAL: begin
            w_pc_load   = 1'b1;
            w_pc_tgt    = w_pc_jmp;
            w_reg_we    = 1'b1;
            w_reg_wa    = 3'd7;
            w_reg_wd    = DATA_W'(w_pc_plus1);
            w_state_nxt = S_FETCH;
          end
          default: w_state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (w_op == OP_ST) begin
          w_mem_we    = 1'b1;
          w_pc_inc    = 1'b1;
          w_state_nxt = S_FETCH;
        end else begin
          w_mdr_load  = 1'b1;
          w_state_nxt = S_WB;
        end
      end
      S_WB: begin
        w_reg_we    = 1'b1;
        w_reg_wd    = (w_op == OP_LD) ? r_mdr : r_res;
        w_pc_inc    = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_OUTW: begin
        if (out_ready) begin
          w_out_clr   = 1'b1;
          w_pc_inc    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge PC_rst) begin
    if (PC_rst) begin
      r_pc        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_flag_z    <= 1'b0;
      r_flag_c    <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (w_pc_clr)       r_pc <= '0;
      else if (w_pc_load) r_pc <= w_pc_tgt;
      else if (w_pc_inc)  r_pc <= w_pc_plus1;
      if (w_ab_load) begin
        r_a <= r_regs[w_ra];
        r_b <= r_regs[w_rb];
      end
      if (w_exec) begin
        r_res <= w_alu_res;
        if (w_flags_we) begin
          r_flag_z <= (w_alu_res == '0);
          r_flag_c <= w_alu_c;
        end
      end
      // r0 stays zero because its writes are dropped here.
      if (w_reg_we && (w_reg_wa != 3'd0)) r_regs[w_reg_wa] <= w_reg_wd;
      if (w_out_load) begin
        r_out_data  <= r_regs[w_ra];
        r_out_valid <= 1'b1;
      end else if (w_out_clr) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_imem_we)  r_imem[ext_addr] <= ext_data;
    if (w_ir_load)  r_ir <= r_imem[r_pc];
    if (w_mem_we)   r_dmem[w_daddr] <= r_regs[w_rd];
    if (w_mdr_load) r_mdr <= r_dmem[w_daddr];
  end

endmodule
